// File: rtl/irq_grant7_pkg.sv
// Shared types and constants for the 7-line interrupt grant controller.
// Imported by the decoder and the top-level FSM.
package irq_grant7_pkg;

   localparam int CODE_W    = 3;
   localparam int NUM_LINES = 7;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

endpackage

// File: rtl/decode7.sv
// 3-to-7 one-hot decoder; code 0 decodes to all-zero, code k sets bit k.
module decode7
   import irq_grant7_pkg::*;
(
   input  logic [CODE_W-1:0]   i_code,
   output logic [NUM_LINES:1]  o_onehot
);

   always_comb begin
      o_onehot = '0;
      for (int k = 1; k <= NUM_LINES; k++) begin
         if (i_code == CODE_W'(k)) o_onehot[k] = 1'b1;
      end
   end

endmodule

// File: rtl/irq_grant7.sv
// Single-grant interrupt arbiter: latches a request code, holds a one-hot grant
// until a four-phase acknowledge completes, and aborts with err on timeout.
module irq_grant7
   import irq_grant7_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
)(
   input  logic                c,
   input  logic                r,
   input  logic [CODE_W-1:0]   y,
   input  logic                e,
   input  logic [NUM_LINES:1]  a,
   output logic [NUM_LINES:1]  g,
   output logic [CODE_W-1:0]   n,
   output logic                busy,
   output logic                err
);

   localparam int              CNT_W     = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [NUM_LINES:1]  r_g, w_g_nxt;
   logic [NUM_LINES:1]  w_req_onehot, w_svc_onehot;
   logic [CODE_W-1:0]   r_n, w_n_nxt;
   logic                r_busy, r_err, w_err_nxt;
   logic                w_ack;

   decode7 u_dec_req (.i_code(y),   .o_onehot(w_req_onehot));
   decode7 u_dec_svc (.i_code(r_n), .o_onehot(w_svc_onehot));

   // Only the acknowledge of the line being serviced is visible to the FSM.
   assign w_ack     = |(a & w_svc_onehot);
   assign w_cnt_inc = r_cnt + CNT_W'(1);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      w_state_nxt = r_state;
      w_g_nxt     = r_g;
      w_n_nxt     = r_n;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = 1'b0;

      unique case (r_state)
         IDLE: begin
            w_g_nxt   = '0;
            w_n_nxt   = '0;
            w_cnt_nxt = '0;
            if (e && (y != '0)) begin
               w_state_nxt = GRANT;
               w_g_nxt     = w_req_onehot;
               w_n_nxt     = y;
            end
         end
         GRANT: begin
            // Acknowledge takes precedence over a coincident timeout.
            if (w_ack) begin
               w_state_nxt = RELEASE;
               w_g_nxt     = '0;
            end else if (w_cnt_inc == TIMEOUT_C) begin
               w_state_nxt = IDLE;
               w_g_nxt     = '0;
               w_n_nxt     = '0;
               w_err_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         RELEASE: begin
            if (!w_ack) begin
               w_state_nxt = IDLE;
               w_n_nxt     = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_g_nxt     = '0;
            w_n_nxt     = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge c or posedge r) begin
      if (r) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_g     <= '0;
         r_n     <= '0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_g     <= w_g_nxt;
         r_n     <= w_n_nxt;
         r_busy  <= (w_state_nxt != IDLE);
         r_err   <= w_err_nxt;
      end
   end

   assign g    = r_g;
   assign n    = r_n;
   assign busy = r_busy;
   assign err  = r_err;

endmodule

// File: tb/tb_irq_grant7.sv
// Directed bench for irq_grant7: expected outputs are queued as each step is
// driven and compared after the following rising edge.
module tb_irq_grant7;
   import irq_grant7_pkg::*;

   logic                c, r, e;
   logic [CODE_W-1:0]   y;
   logic [NUM_LINES:1]  a;
   logic [NUM_LINES:1]  g4, g3;
   logic [CODE_W-1:0]   n4, n3;
   logic                busy4, busy3, err4, err3;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      string       tag;
      bit          sel3;
      logic [11:0] exp;
   } exp_t;

   exp_t sb[$];

   irq_grant7 #(.TIMEOUT(4)) u_dut4 (
      .c(c), .r(r), .y(y), .e(e), .a(a),
      .g(g4), .n(n4), .busy(busy4), .err(err4)
   );

   irq_grant7 #(.TIMEOUT(3)) u_dut3 (
      .c(c), .r(r), .y(y), .e(e), .a(a),
      .g(g3), .n(n3), .busy(busy3), .err(err3)
   );

   initial c = 1'b0;
   always #5 c = ~c;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push(input string tag, input bit sel3, input logic [7:1] eg,
                       input logic [2:0] en, input logic eb, input logic ee);
      exp_t x;
      x.tag  = tag;
      x.sel3 = sel3;
      x.exp  = {eg, en, eb, ee};
      sb.push_back(x);
   endtask

   task automatic pop_check();
      exp_t        x;
      logic [11:0] obs;
      n_total++;
      if (sb.size() == 0) begin
         $error("FAIL scoreboard_empty observed=none expected=entry");
      end else begin
         x   = sb.pop_front();
         obs = x.sel3 ? {g3, n3, busy3, err3} : {g4, n4, busy4, err4};
         assert (obs === x.exp) n_pass++;
         else $error("FAIL %s observed={g,n,busy,err}=%h expected=%h", x.tag, obs, x.exp);
      end
   endtask

   task automatic step(input string tag, input bit sel3, input logic [7:1] eg,
                       input logic [2:0] en, input logic eb, input logic ee);
      push(tag, sel3, eg, en, eb, ee);
      @(posedge c);
      #1;
      pop_check();
   endtask

   initial begin
      r = 1'b1; y = '0; e = 1'b0; a = '0;
      @(posedge c);
      step("reset_hold", 0, 7'b0, 3'd0, 1'b0, 1'b0);

      // Basic grant / four-phase release on line 3
      r = 1'b0; y = 3'd3; e = 1'b1;
      step("grant_l3", 0, 7'b0000100, 3'd3, 1'b1, 1'b0);
      a = 7'b0000100; y = 3'd0; e = 1'b0;
      step("ack_l3", 0, 7'b0, 3'd3, 1'b1, 1'b0);
      a = '0; e = 1'b1; y = 3'd2;
      step("release_gap", 0, 7'b0, 3'd0, 1'b0, 1'b0);

      // Timeout on line 2 (TIMEOUT=4)
      step("grant_l2", 0, 7'b0000010, 3'd2, 1'b1, 1'b0);
      y = 3'd0; e = 1'b0;
      for (int i = 0; i < 3; i++) step("to_hold", 0, 7'b0000010, 3'd2, 1'b1, 1'b0);
      step("to_err", 0, 7'b0, 3'd0, 1'b0, 1'b1);
      step("to_err_clr", 0, 7'b0, 3'd0, 1'b0, 1'b0);

      // Disabled acceptance
      y = 3'd5; e = 1'b0;
      for (int i = 0; i < 10; i++) step("e0_idle", 0, 7'b0, 3'd0, 1'b0, 1'b0);

      // Foreign acknowledge and request changes are ignored during GRANT
      y = 3'd6; e = 1'b1; a = '0;
      step("grant_l6", 0, 7'b0100000, 3'd6, 1'b1, 1'b0);
      y = 3'd1; e = 1'b0; a = 7'b0000001;
      step("other_ack", 0, 7'b0100000, 3'd6, 1'b1, 1'b0);
      a = '0;
      step("y_change_hold", 0, 7'b0100000, 3'd6, 1'b1, 1'b0);
      a = 7'b0100000;
      step("ack_l6", 0, 7'b0, 3'd6, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step("release_wait", 0, 7'b0, 3'd6, 1'b1, 1'b0);
      a = '0;
      step("release_l6", 0, 7'b0, 3'd0, 1'b0, 1'b0);

      // Asynchronous reset mid-GRANT
      y = 3'd4; e = 1'b1;
      step("grant_l4", 0, 7'b0001000, 3'd4, 1'b1, 1'b0);
      y = 3'd0; e = 1'b0;
      #2;
      r = 1'b1;
      #1;
      push("async_rst", 0, 7'b0, 3'd0, 1'b0, 1'b0);
      pop_check();
      push("async_rst_t3", 1, 7'b0, 3'd0, 1'b0, 1'b0);
      pop_check();
      step("rst_held", 0, 7'b0, 3'd0, 1'b0, 1'b0);
      r = 1'b0;
      step("post_rst", 0, 7'b0, 3'd0, 1'b0, 1'b0);

      // Acknowledge coincident with timeout (TIMEOUT=3)
      y = 3'd1; e = 1'b1;
      step("co_grant", 1, 7'b0000001, 3'd1, 1'b1, 1'b0);
      y = 3'd0; e = 1'b0;
      step("co_cnt1", 1, 7'b0000001, 3'd1, 1'b1, 1'b0);
      step("co_cnt2", 1, 7'b0000001, 3'd1, 1'b1, 1'b0);
      a = 7'b0000001;
      step("co_ack", 1, 7'b0, 3'd1, 1'b1, 1'b0);
      step("co_no_err", 1, 7'b0, 3'd1, 1'b1, 1'b0);
      a = '0;
      step("co_done", 1, 7'b0, 3'd0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
